// File: rtl/arcade_input_mapper.sv
// Arcade input front-end: PS/2 key events and per-player joystick words become per-player cabinet input bytes (active-low).
// Latency: joy -> in_n 1 cycle, key event -> in_n 2 cycles; coin/autofire shaping is folded into the same output register.
// Backpressure: none; every output is recomputed and registered on every clock.
// Ports: clk, reset_n (synchronous, active-low), ps2_key {toggle,pressed,ext,code}, joy (16 bits per player),
//        tick (timebase strobe), socd_mode, autofire_en (per player), in_n (8 active-low bits per player).
module arcade_input_mapper #(
    parameter int PLAYERS    = 2,
    parameter int COIN_TICKS = 4,
    parameter int AF_TICKS   = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [10:0]             ps2_key,
    input  logic [16*PLAYERS-1:0]   joy,
    input  logic                    tick,
    input  logic [1:0]              socd_mode,
    input  logic [PLAYERS-1:0]      autofire_en,
    output logic [8*PLAYERS-1:0]    in_n
);

    // Internal per-player bit layout matches the joy word:
    // [0]right [1]left [2]down [3]up [4]fire [5]fire2 [6]start [7]coin
    logic                        r_tog;
    logic [PLAYERS-1:0][7:0]     r_key;
    logic [PLAYERS-1:0][3:0]     r_dir_prev;
    logic [PLAYERS-1:0]          r_ud_b;       // 1: down owns a simultaneous up+down
    logic [PLAYERS-1:0]          r_lr_b;       // 1: right owns a simultaneous left+right
    logic [PLAYERS-1:0]          r_coin_prev;
    logic [PLAYERS-1:0]          r_coin_act;
    logic [PLAYERS-1:0][7:0]     r_coin_cnt;
    logic [PLAYERS-1:0]          r_af_phase;
    logic [PLAYERS-1:0][7:0]     r_af_cnt;
    logic [PLAYERS-1:0]          r_af_hold;    // fire was held with autofire on last cycle
    logic [PLAYERS-1:0][7:0]     r_in_n;

    logic                        w_evt;
    logic                        w_kv;
    logic [1:0]                  w_kp;
    logic [2:0]                  w_kb;
    logic [PLAYERS-1:0][7:0]     w_raw;
    logic [PLAYERS-1:0][7:0]     w_out;        // active-high, output byte layout
    logic [PLAYERS-1:0]          w_ud_b_n;
    logic [PLAYERS-1:0]          w_lr_b_n;
    logic [PLAYERS-1:0]          w_coin_act_n;
    logic [PLAYERS-1:0][7:0]     w_coin_cnt_n;
    logic [PLAYERS-1:0]          w_af_phase_n;
    logic [PLAYERS-1:0][7:0]     w_af_cnt_n;
    logic                        w_unused;

    assign w_evt = ps2_key[10] ^ r_tog;
    assign in_n  = r_in_n;

    // Returns {b_wins_next, out_a, out_b}. "a" is up/left, which wins a same-cycle tie.
    function automatic logic [2:0] socd(input logic [1:0] mode, input logic a, input logic b,
                                        input logic pa, input logic pb, input logic wb);
        logic wbn, oa, ob;
        wbn = wb;
        if (a && !pa)      wbn = 1'b0;
        else if (b && !pb) wbn = 1'b1;
        oa = a;
        ob = b;
        if (a && b) begin
            if (mode == 2'd1) begin
                oa = 1'b0;
                ob = 1'b0;
            end else if (mode == 2'd2) begin
                oa = !wbn;
                ob = wbn;
            end
        end
        return {wbn, oa, ob};
    endfunction

    // {ext,code} -> player and bit; codes for players beyond PLAYERS decode but never match a register.
    always_comb begin
        w_kv = 1'b1;
        w_kp = 2'd0;
        w_kb = 3'd0;
        case ({ps2_key[8], ps2_key[7:0]})
            9'h175: {w_kp, w_kb} = {2'd0, 3'd3};
            9'h172: {w_kp, w_kb} = {2'd0, 3'd2};
            9'h16B: {w_kp, w_kb} = {2'd0, 3'd1};
            9'h174: {w_kp, w_kb} = {2'd0, 3'd0};
            9'h029, 9'h014, 9'h114: {w_kp, w_kb} = {2'd0, 3'd4};
            9'h011: {w_kp, w_kb} = {2'd0, 3'd5};
            9'h016, 9'h005: {w_kp, w_kb} = {2'd0, 3'd6};
            9'h02E: {w_kp, w_kb} = {2'd0, 3'd7};
            9'h02D: {w_kp, w_kb} = {2'd1, 3'd3};
            9'h02B: {w_kp, w_kb} = {2'd1, 3'd2};
            9'h023: {w_kp, w_kb} = {2'd1, 3'd1};
            9'h034: {w_kp, w_kb} = {2'd1, 3'd0};
            9'h01C: {w_kp, w_kb} = {2'd1, 3'd4};
            9'h01B: {w_kp, w_kb} = {2'd1, 3'd5};
            9'h01E, 9'h006: {w_kp, w_kb} = {2'd1, 3'd6};
            9'h036: {w_kp, w_kb} = {2'd1, 3'd7};
            9'h043: {w_kp, w_kb} = {2'd2, 3'd3};
            9'h042: {w_kp, w_kb} = {2'd2, 3'd2};
            9'h03B: {w_kp, w_kb} = {2'd2, 3'd1};
            9'h04B: {w_kp, w_kb} = {2'd2, 3'd0};
            9'h01D: {w_kp, w_kb} = {2'd2, 3'd4};
            9'h022: {w_kp, w_kb} = {2'd2, 3'd5};
            9'h026: {w_kp, w_kb} = {2'd2, 3'd6};
            9'h03D: {w_kp, w_kb} = {2'd2, 3'd7};
            9'h075: {w_kp, w_kb} = {2'd3, 3'd3};
            9'h072: {w_kp, w_kb} = {2'd3, 3'd2};
            9'h06B: {w_kp, w_kb} = {2'd3, 3'd1};
            9'h074: {w_kp, w_kb} = {2'd3, 3'd0};
            9'h070: {w_kp, w_kb} = {2'd3, 3'd4};
            9'h071: {w_kp, w_kb} = {2'd3, 3'd5};
            9'h025: {w_kp, w_kb} = {2'd3, 3'd6};
            9'h03E: {w_kp, w_kb} = {2'd3, 3'd7};
            default: w_kv = 1'b0;
        endcase
    end

    always_comb begin
        w_raw        = '0;
        w_out        = '0;
        w_ud_b_n     = '0;
        w_lr_b_n     = '0;
        w_coin_act_n = '0;
        w_coin_cnt_n = '0;
        w_af_phase_n = '0;
        w_af_cnt_n   = '0;
        w_unused     = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            w_unused = w_unused ^ (^joy[16*p+8 +: 8]);
            w_raw[p] = r_key[p] | joy[16*p +: 8];

            {w_ud_b_n[p], w_out[p][0], w_out[p][1]} = socd(socd_mode, w_raw[p][3], w_raw[p][2],
                                                          r_dir_prev[p][3], r_dir_prev[p][2], r_ud_b[p]);
            {w_lr_b_n[p], w_out[p][2], w_out[p][3]} = socd(socd_mode, w_raw[p][1], w_raw[p][0],
                                                          r_dir_prev[p][1], r_dir_prev[p][0], r_lr_b[p]);

            // Coin: a fresh press arms the pulse (same-cycle tick ignored); ticks count only while armed.
            w_coin_act_n[p] = r_coin_act[p];
            w_coin_cnt_n[p] = r_coin_cnt[p];
            if (!r_coin_act[p]) begin
                if (w_raw[p][7] && !r_coin_prev[p]) begin
                    w_coin_act_n[p] = 1'b1;
                    w_coin_cnt_n[p] = '0;
                end
            end else if (tick) begin
                if (r_coin_cnt[p] == 8'(COIN_TICKS - 1)) begin
                    w_coin_act_n[p] = 1'b0;
                    w_coin_cnt_n[p] = '0;
                end else begin
                    w_coin_cnt_n[p] = r_coin_cnt[p] + 8'd1;
                end
            end

            // Autofire: phase parks at "asserted" whenever fire or autofire is off, so a press
            // or an enable change always starts with fire on. Press-cycle ticks are not counted.
            w_af_phase_n[p] = r_af_phase[p];
            w_af_cnt_n[p]   = r_af_cnt[p];
            if (!w_raw[p][4] || !autofire_en[p]) begin
                w_af_phase_n[p] = 1'b1;
                w_af_cnt_n[p]   = '0;
            end else if (tick && r_af_hold[p]) begin
                if (r_af_cnt[p] == 8'(AF_TICKS - 1)) begin
                    w_af_phase_n[p] = !r_af_phase[p];
                    w_af_cnt_n[p]   = '0;
                end else begin
                    w_af_cnt_n[p] = r_af_cnt[p] + 8'd1;
                end
            end

            w_out[p][4] = autofire_en[p] ? (w_raw[p][4] && w_af_phase_n[p]) : w_raw[p][4];
            w_out[p][5] = w_raw[p][6];
            w_out[p][6] = w_coin_act_n[p];
            w_out[p][7] = w_raw[p][5];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tog      <= ps2_key[10];
            r_key      <= '0;
            r_dir_prev <= '0;
            r_ud_b     <= '0;
            r_lr_b     <= '0;
            r_coin_act <= '0;
            r_coin_cnt <= '0;
            r_af_phase <= '1;
            r_af_cnt   <= '0;
            r_af_hold  <= '0;
            r_in_n     <= '1;
            // A coin still held across reset must not look like a fresh press afterwards.
            for (int p = 0; p < PLAYERS; p++) begin
                r_coin_prev[p] <= joy[16*p+7];
            end
        end else begin
            r_tog <= ps2_key[10];
            for (int p = 0; p < PLAYERS; p++) begin
                if (w_evt && w_kv && (w_kp == 2'(p))) begin
                    r_key[p][w_kb] <= ps2_key[9];
                end
                r_dir_prev[p]  <= w_raw[p][3:0];
                r_coin_prev[p] <= w_raw[p][7];
                r_af_hold[p]   <= w_raw[p][4] && autofire_en[p];
                r_in_n[p]      <= ~w_out[p];
            end
            r_ud_b     <= w_ud_b_n;
            r_lr_b     <= w_lr_b_n;
            r_coin_act <= w_coin_act_n;
            r_coin_cnt <= w_coin_cnt_n;
            r_af_phase <= w_af_phase_n;
            r_af_cnt   <= w_af_cnt_n;
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper (PLAYERS=2, COIN_TICKS=4, AF_TICKS=3).
// Stimulus queues the in_n value expected at a given cycle; a negedge monitor pops and compares.
// Expected values are hand-derived constants per directed step.
module tb_arcade_input_mapper;

    logic        clk;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [31:0] joy;
    logic        tick;
    logic [1:0]  socd_mode;
    logic [1:0]  autofire_en;
    logic [15:0] in_n;

    typedef struct {
        int          cyc;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    arcade_input_mapper #(.PLAYERS(2), .COIN_TICKS(4), .AF_TICKS(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .joy         (joy),
        .tick        (tick),
        .socd_mode   (socd_mode),
        .autofire_en (autofire_en),
        .in_n        (in_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every queued expectation whose cycle has arrived.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].cyc <= cyc) begin
                n_checks++;
                if (sb_q[i].cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                             sb_q[i].name, sb_q[i].cyc, cyc);
                end else if (in_n !== sb_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d in_n=%h expected %h",
                             sb_q[i].name, cyc, in_n, sb_q[i].exp);
                end
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_at(input int dly, input logic [15:0] e, input string nm);
        exp_t x;
        x.cyc  = cyc + dly;
        x.exp  = e;
        x.name = nm;
        sb_q.push_back(x);
    endtask

    task automatic run(input int n, input logic [15:0] e, input string nm);
        for (int i = 0; i < n; i++) begin
            expect_at(1, e, nm);
            step();
        end
    endtask

    // One tick strobe followed by two idle cycles; in_n must hold e from the tick edge on.
    task automatic tick_period(input logic [15:0] e, input string nm);
        tick = 1'b1;
        expect_at(1, e, nm);
        step();
        tick = 1'b0;
        expect_at(1, e, nm);
        step();
        expect_at(1, e, nm);
        step();
    endtask

    function automatic logic [10:0] key(input logic t, input logic pr, input logic ex, input logic [7:0] c);
        return {t, pr, ex, c};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        joy         = 32'hFFFF_FFFF;
        ps2_key     = key(1'b1, 1'b1, 1'b1, 8'h75);
        tick        = 1'b0;
        socd_mode   = 2'd0;
        autofire_en = 2'b00;

        // Reset with everything pressed, then release with the toggle already high.
        step();
        expect_at(0, 16'hFFFF, "reset_all_pressed");
        run(2, 16'hFFFF, "reset_hold");
        joy = 32'h0;
        run(1, 16'hFFFF, "reset_joy_clear");
        reset_n = 1'b1;
        run(4, 16'hFFFF, "no_event_after_reset");

        // Key path, two-cycle latency.
        ps2_key = key(1'b0, 1'b1, 1'b1, 8'h75);
        expect_at(1, 16'hFFFF, "key_lat1");
        expect_at(2, 16'hFFFE, "key_up_press");
        step(); step();
        run(2, 16'hFFFE, "key_up_hold");
        ps2_key = key(1'b1, 1'b0, 1'b1, 8'h75);
        expect_at(1, 16'hFFFE, "key_rel_lat1");
        expect_at(2, 16'hFFFF, "key_up_release");
        step(); step();
        ps2_key = key(1'b0, 1'b1, 1'b0, 8'h75);
        expect_at(2, 16'hFFFF, "key_p4_discard");
        step(); step();
        run(2, 16'hFFFF, "key_p4_discard_hold");
        ps2_key = key(1'b1, 1'b1, 1'b0, 8'h2D);
        expect_at(2, 16'hFEFF, "key_p2_up");
        step(); step();
        ps2_key = key(1'b0, 1'b0, 1'b0, 8'h2D);
        expect_at(2, 16'hFFFF, "key_p2_up_release");
        step(); step();
        ps2_key = key(1'b1, 1'b1, 1'b1, 8'h14);
        expect_at(2, 16'hFFEF, "key_p1_fire_ext14");
        step(); step();
        ps2_key = key(1'b0, 1'b0, 1'b1, 8'h14);
        expect_at(2, 16'hFFFF, "key_p1_fire_release");
        step(); step();

        // SOCD last-pressed-wins.
        socd_mode = 2'd2;
        joy = 32'h8;
        run(5, 16'hFFFE, "socd2_up");
        joy = 32'hC;
        run(3, 16'hFFFD, "socd2_down_wins");
        joy = 32'h8;
        run(1, 16'hFFFE, "socd2_up_returns");
        joy = 32'h0;
        run(1, 16'hFFFF, "socd2_idle");
        joy = 32'hC;
        run(2, 16'hFFFE, "socd2_tie_up");
        joy = 32'h4;
        run(1, 16'hFFFD, "socd2_down_only");
        joy = 32'h3;
        run(2, 16'hFFFB, "socd2_tie_left");
        socd_mode = 2'd1;
        joy = 32'hC;
        run(2, 16'hFFFF, "socd1_neutral");
        socd_mode = 2'd0;
        run(1, 16'hFFFC, "socd0_pass");
        socd_mode = 2'd3;
        run(1, 16'hFFFC, "socd3_pass");
        joy = 32'h0;
        socd_mode = 2'd0;
        run(1, 16'hFFFF, "socd_idle");

        // Coin: four-tick pulse, then stays high while held.
        joy = 32'h80;
        run(1, 16'hFFBF, "coin_start");
        for (int k = 1; k <= 20; k++) begin
            tick_period((k < 4) ? 16'hFFBF : 16'hFFFF, "coin_pulse");
        end
        joy = 32'h0;
        run(1, 16'hFFFF, "coin_release");
        joy = 32'h80;
        run(1, 16'hFFBF, "coin_repress");
        for (int k = 1; k <= 6; k++) begin
            tick_period((k < 4) ? 16'hFFBF : 16'hFFFF, "coin_repulse");
        end

        // Reset mid-pulse with coin still held.
        joy = 32'h0;
        run(1, 16'hFFFF, "coin_release2");
        joy = 32'h80;
        run(1, 16'hFFBF, "coin_press_pre_rst");
        tick_period(16'hFFBF, "coin_pre_rst");
        reset_n = 1'b0;
        run(2, 16'hFFFF, "rst_mid_pulse");
        reset_n = 1'b1;
        run(2, 16'hFFFF, "no_pulse_after_rst");
        tick_period(16'hFFFF, "no_pulse_after_rst_tick");
        joy = 32'h0;
        run(1, 16'hFFFF, "coin_release3");
        joy = 32'h80;
        run(1, 16'hFFBF, "coin_after_rst");
        for (int k = 1; k <= 4; k++) begin
            tick_period((k < 4) ? 16'hFFBF : 16'hFFFF, "coin_after_rst_pulse");
        end
        joy = 32'h0;
        run(1, 16'hFFFF, "coin_idle");

        // Autofire on P1: low for 3 ticks, high for 3 ticks, ...
        autofire_en = 2'b01;
        joy = 32'h10;
        run(1, 16'hFFEF, "af_press");
        for (int k = 1; k <= 12; k++) begin
            tick_period(((k / 3) % 2 == 0) ? 16'hFFEF : 16'hFFFF, "af_phase");
        end
        joy = 32'h0;
        run(1, 16'hFFFF, "af_release");
        joy = 32'h10;
        run(1, 16'hFFEF, "af_repress");
        for (int k = 1; k <= 3; k++) begin
            tick_period((k < 3) ? 16'hFFEF : 16'hFFFF, "af_second_hold");
        end
        autofire_en = 2'b00;
        run(1, 16'hFFEF, "af_disable");
        tick_period(16'hFFEF, "af_disabled_tick");
        autofire_en = 2'b01;
        run(1, 16'hFFEF, "af_reenable");
        for (int k = 1; k <= 3; k++) begin
            tick_period((k < 3) ? 16'hFFEF : 16'hFFFF, "af_reenable_hold");
        end
        joy = 32'h0010_0000;
        run(1, 16'hEFFF, "af_off_p2_press");
        for (int k = 1; k <= 4; k++) begin
            tick_period(16'hEFFF, "af_off_p2_hold");
        end
        joy = 32'h0;
        run(3, 16'hFFFF, "final_idle");

        repeat (3) step();
        while (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", sb_q[0].name, sb_q[0].cyc);
            sb_q.delete(0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parameterised input front-end for arcade cores: decodes PS/2 key events and per-player joystick words into per-player active-low cabinet input bytes.
- Adds coin pulse shaping, per-player autofire and selectable opposing-direction (SOCD) resolution.
- Sits between hps_io and the game core; replaces ad-hoc per-core keyboard decode.

Parameters:
PLAYERS, 2, number of player channels (1..4)
COIN_TICKS, 4, coin pulse length in tick strobes (1..255)
AF_TICKS, 3, autofire half-period in tick strobes (1..255)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
joy  in  16*PLAYERS  player p at [16p+15:16p]; [0]right [1]left [2]down [3]up [4]fire [5]fire2 [6]start [7]coin
tick  in  1  one-cycle timebase strobe (e.g. once per frame)
socd_mode  in  2  0 passthrough, 1 neutral, 2 last-pressed wins, 3 = passthrough
autofire_en  in  PLAYERS  per-player autofire enable on fire
in_n  out  8*PLAYERS  player p at [8p+7:8p]; [0]up [1]down [2]left [3]right [4]fire [5]start [6]coin [7]fire2; active-low

Behaviour:
- Reset (reset_n=0 at an edge): in_n all 1s. Key-state bits, SOCD history, coin and autofire counters cleared. Toggle tracker loaded with ps2_key[10], so no event is decoded on release.
- Key event: at an edge where ps2_key[10] differs from the tracker, the matching key-state bit is set to ps2_key[9] and the tracker updates. Unmapped codes are ignored.
- Key map as {ext,code}; ports are named for the inputs they drive:
  - P1: up/down/left/right 175/172/16B/174; fire 029, 014, 114; fire2 011; start 016, 005; coin 02E.
  - P2: 02D/02B/023/034; fire 01C; fire2 01B; start 01E, 006; coin 036.
  - P3: 043/042/03B/04B; fire 01D; fire2 022; start 026; coin 03D.
  - P4: 075/072/06B/074; fire 070; fire2 071; start 025; coin 03E.
  - Keys for players >= PLAYERS are decoded and discarded.
- Merge: raw[p] = key bits OR the corresponding joy bits.
- Latency: in_n is registered. Joy to in_n is 1 cycle; key event to in_n is 2 cycles (excluding autofire/coin gating).
- SOCD, applied independently to the up/down pair and the left/right pair:
  - Mode 1: both raw bits set -> both outputs clear.
  - Mode 2: the most recently newly-set bit wins. If both become set in the same cycle, up (or left) wins. When the winner is released and the other is still held, the other asserts.
- Coin, per player:
  - A raw coin rising edge starts a pulse. Coin asserts on the next edge and stays asserted until COIN_TICKS tick strobes have been counted, then deasserts on the edge after the final tick.
  - Rising edges during an active pulse are ignored.
  - After the pulse ends, coin stays deasserted until raw coin is released and pressed again.
  - A tick in the same cycle as pulse start is not counted.
- Autofire (autofire_en[p]=1), fire only:
  - On press, fire asserts immediately. The phase toggles after every AF_TICKS ticks while held.
  - On release, fire deasserts next cycle and the phase and counter reset.
  - autofire_en=0: fire passes through unchanged.
  - Changing autofire_en mid-hold takes effect next cycle, with phase reset to asserted.
- Start, fire2 and directions after SOCD pass through unchanged. All outputs are inverted to active-low.

Test Plan:
- Reset: hold reset_n=0 with joy all 1s -> in_n=16'hFFFF. Release with ps2_key[10]=1 -> still FFFF, no event decoded.
- Key path: toggle ps2_key with {pressed=1,ext=1,code=75} -> in_n[0]=0 two cycles later. Same key with pressed=0 -> in_n[0]=1. Non-extended 075 with PLAYERS=2 -> no change.
- SOCD mode 2: joy P1 up, then down 5 cycles later -> in_n[1:0]=2'b01 (down wins). Release down -> 2'b10 (up). Mode 1 with both held -> 2'b11.
- Coin: COIN_TICKS=4, hold joy coin for 20 ticks -> in_n[6] low for exactly 4 ticks, then high while still held. Re-press -> new 4-tick pulse.
- Autofire: AF_TICKS=3, en=1, hold fire 12 ticks -> in_n[4] alternates low/high every 3 ticks, starting low. Release -> high next cycle.
- Reset mid-pulse: assert reset_n=0 during a coin pulse -> in_n[6]=1 next edge. After release, coin is still held -> no pulse until re-pressed.
